// File: rtl/sdram_burst_sched_if.sv
// Scheduler <-> SDRAM controller burst handshake: requests, acks and burst start addresses.
interface sdram_burst_sched_if #(
  parameter int ADDR_W = 22
);
  logic              sdram_wr_req;
  logic              sdram_rd_req;
  logic              sdram_wr_ack;
  logic              sdram_rd_ack;
  logic [ADDR_W-1:0] sys_wr_addr;
  logic [ADDR_W-1:0] sys_rd_addr;

  modport master (
    output sdram_wr_req, sdram_rd_req, sys_wr_addr, sys_rd_addr,
    input  sdram_wr_ack, sdram_rd_ack
  );

  modport slave (
    input  sdram_wr_req, sdram_rd_req, sys_wr_addr, sys_rd_addr,
    output sdram_wr_ack, sdram_rd_ack
  );
endinterface

// File: rtl/sdram_burst_sched.sv
// SDRAM burst request scheduler: one outstanding write/read burst, wrapping burst addresses, stored-burst level.
// Optional SDRAM_SCHED_RR_EN: round-robin write/read priority (default fixed write-first).
module sdram_burst_sched #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 22,
  parameter int ADDR_MIN  = 0,
  parameter int ADDR_MAX  = 4194303,
  parameter int FIFO_W    = 9,
  parameter int RDF_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_done,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_W-1:0]     wrf_usedw,
  input  logic [FIFO_W-1:0]     rdf_usedw,
  sdram_burst_sched_if.master   bus,
  output logic [ADDR_W-1:0]     level,
  output logic                  burst_err
);
  localparam int CAP   = (ADDR_MAX - ADDR_MIN + 1) / BURST_LEN;
  localparam int CNT_W = $clog2(BURST_LEN + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_BL  = CNT_W'(BURST_LEN);
  localparam logic [FIFO_W-1:0] WRF_MIN = FIFO_W'(BURST_LEN);
  localparam logic [FIFO_W-1:0] RDF_LIM = FIFO_W'(RDF_DEPTH - BURST_LEN);
  localparam logic [ADDR_W:0]   WRAP_AT = (ADDR_W+1)'(ADDR_MAX - BURST_LEN + 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_req, rd_req;
  logic              wr_ok, rd_ok, pick_wr;
  logic              done_wr, done_rd, stray_ack;
  logic [ADDR_W:0]   wr_sum, rd_sum;
  logic [ADDR_W-1:0] wr_addr_nxt, rd_addr_nxt;

  assign wr_ok = init_done & wr_en & (wrf_usedw >= WRF_MIN) & (level < ADDR_W'(CAP));
  assign rd_ok = init_done & rd_en & (level != '0) & (rdf_usedw <= RDF_LIM);

`ifdef SDRAM_SCHED_RR_EN
  // Last-served flag resets to "read" so the first contested slot goes to write.
  logic last_rd;
  assign pick_wr = wr_ok & (~rd_ok | last_rd);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                     last_rd <= 1'b1;
    else if (state == IDLE && state_nxt == WR_REQ)  last_rd <= 1'b0;
    else if (state == IDLE && state_nxt == RD_REQ)  last_rd <= 1'b1;
`else
  assign pick_wr = wr_ok;
`endif

  always_comb begin
    state_nxt = state;
    done_wr   = 1'b0;
    done_rd   = 1'b0;
    case (state)
      IDLE:    if (pick_wr) state_nxt = WR_REQ;
               else if (rd_ok) state_nxt = RD_REQ;
      WR_REQ:  if (bus.sdram_wr_ack) state_nxt = WR_BUSY;
      WR_BUSY: if (!bus.sdram_wr_ack) begin state_nxt = IDLE; done_wr = 1'b1; end
      RD_REQ:  if (bus.sdram_rd_ack) state_nxt = RD_BUSY;
      RD_BUSY: if (!bus.sdram_rd_ack) begin state_nxt = IDLE; done_rd = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end

  assign stray_ack = (bus.sdram_wr_ack & ~(state == WR_REQ || state == WR_BUSY)) |
                     (bus.sdram_rd_ack & ~(state == RD_REQ || state == RD_BUSY));

  // Extra carry bit so the wrap compare cannot overflow when ADDR_MAX fills ADDR_W.
  assign wr_sum      = {1'b0, wr_addr} + (ADDR_W+1)'(BURST_LEN);
  assign rd_sum      = {1'b0, rd_addr} + (ADDR_W+1)'(BURST_LEN);
  assign wr_addr_nxt = (wr_sum > WRAP_AT) ? ADDR_W'(ADDR_MIN) : wr_sum[ADDR_W-1:0];
  assign rd_addr_nxt = (rd_sum > WRAP_AT) ? ADDR_W'(ADDR_MIN) : rd_sum[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      wr_addr   <= ADDR_W'(ADDR_MIN);
      rd_addr   <= ADDR_W'(ADDR_MIN);
      level     <= '0;
      burst_err <= 1'b0;
      wr_req    <= 1'b0;
      rd_req    <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_req <= (state_nxt == WR_REQ);
      rd_req <= (state_nxt == RD_REQ);
      if ((state == WR_REQ && bus.sdram_wr_ack) || (state == RD_REQ && bus.sdram_rd_ack))
        beat_cnt <= CNT_W'(1);
      else if ((state == WR_BUSY && bus.sdram_wr_ack) || (state == RD_BUSY && bus.sdram_rd_ack))
        beat_cnt <= (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + 1'b1;
      else if (done_wr || done_rd)
        beat_cnt <= '0;
      if (done_wr) begin
        wr_addr <= wr_addr_nxt;
        level   <= level + 1'b1;
      end
      if (done_rd) begin
        rd_addr <= rd_addr_nxt;
        level   <= level - 1'b1;
      end
      if (stray_ack || ((done_wr || done_rd) && beat_cnt != CNT_BL))
        burst_err <= 1'b1;
    end
  end

  assign bus.sdram_wr_req = wr_req;
  assign bus.sdram_rd_req = rd_req;
  assign bus.sys_wr_addr  = wr_addr;
  assign bus.sys_rd_addr  = rd_addr;
endmodule

// File: tb/tb_sdram_burst_sched.sv
// Directed self-checking bench for sdram_burst_sched (64-word region, 8-beat bursts, CAP = 8).
module tb_sdram_burst_sched;
  localparam int BL = 8;
  localparam int AW = 22;
  localparam int AMAX = 63;
  localparam int FW = 9;

  logic clk = 1'b0;
  logic rst_n, init_done, wr_en, rd_en;
  logic [FW-1:0] wrf_usedw, rdf_usedw;
  logic [AW-1:0] level;
  logic burst_err;
  int vecs = 0;
  int errs = 0;

  sdram_burst_sched_if #(.ADDR_W(AW)) bus ();

  sdram_burst_sched #(
    .BURST_LEN(BL), .ADDR_W(AW), .ADDR_MIN(0), .ADDR_MAX(AMAX),
    .FIFO_W(FW), .RDF_DEPTH(256)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .wr_en(wr_en), .rd_en(rd_en),
    .wrf_usedw(wrf_usedw), .rdf_usedw(rdf_usedw), .bus(bus),
    .level(level), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset(input logic w_en, input logic r_en, input int wrf);
    @(negedge clk);
    rst_n = 1'b0;
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    init_done = 1'b1;
    wr_en = w_en;
    rd_en = r_en;
    wrf_usedw = FW'(wrf);
    rdf_usedw = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Controller model: wait for a request, ack it for n beats, return just after completion edge.
  task automatic burst(input int n, output bit got_rd);
    bit seen = 1'b0;
    got_rd = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.sdram_wr_req || bus.sdram_rd_req) begin seen = 1'b1; break; end
    end
    vecs++;
    if (!seen) begin
      errs++;
      $display("FAIL req_timeout: no request within 50 cycles, expected one");
      return;
    end
    got_rd = bus.sdram_rd_req;
    if (got_rd) bus.sdram_rd_ack = 1'b1; else bus.sdram_wr_ack = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if ((bus.sdram_wr_req | bus.sdram_rd_req) !== 1'b0) begin
      errs++;
      $display("FAIL req_drop: req=%b after first ack edge, expected 0",
               bus.sdram_wr_req | bus.sdram_rd_req);
    end
    repeat (n - 1) @(posedge clk);
    @(negedge clk);
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    init_done = 1'b1; wr_en = 1'b1; rd_en = 1'b0;
    wrf_usedw = FW'(20); rdf_usedw = '0;
    bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({bus.sdram_wr_req, bus.sdram_rd_req, burst_err} !== 3'b000 ||
        bus.sys_wr_addr !== '0 || bus.sys_rd_addr !== '0 || level !== '0) begin
      errs++;
      $display("FAIL reset_vals: wr_req=%b rd_req=%b err=%b wa=%0d ra=%0d lvl=%0d, expected all 0",
               bus.sdram_wr_req, bus.sdram_rd_req, burst_err, bus.sys_wr_addr, bus.sys_rd_addr, level);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vecs++;
    if (bus.sdram_wr_req !== 1'b0) begin
      errs++; $display("FAIL reset_rel_c1: wr_req=%b, expected 0", bus.sdram_wr_req);
    end
    @(posedge clk); #1;
    vecs++;
    if (bus.sdram_wr_req !== 1'b1) begin
      errs++; $display("FAIL reset_rel_c2: wr_req=%b, expected 1", bus.sdram_wr_req);
    end
  endtask

  task automatic test_single_write_then_read();
    bit rd;
    do_reset(1'b1, 1'b0, 8);
    @(posedge clk); #1;
    wrf_usedw = '0;
    burst(8, rd);
    vecs++;
    if (rd !== 1'b0 || bus.sys_wr_addr !== AW'(8) || level !== AW'(1) || burst_err !== 1'b0) begin
      errs++;
      $display("FAIL single_wr: rd=%b wa=%0d lvl=%0d err=%b, expected rd=0 wa=8 lvl=1 err=0",
               rd, bus.sys_wr_addr, level, burst_err);
    end
    rd_en = 1'b1;
    burst(8, rd);
    vecs++;
    if (rd !== 1'b1 || bus.sys_rd_addr !== AW'(8) || level !== '0 || bus.sys_wr_addr !== AW'(8)) begin
      errs++;
      $display("FAIL rd_after_wr: rd=%b ra=%0d lvl=%0d wa=%0d, expected rd=1 ra=8 lvl=0 wa=8",
               rd, bus.sys_rd_addr, level, bus.sys_wr_addr);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (bus.sdram_rd_req !== 1'b0) begin
        errs++; $display("FAIL rd_empty_hold: rd_req=%b cycle %0d, expected 0", bus.sdram_rd_req, i);
      end
    end
  endtask

  task automatic test_wrap_full();
    bit rd;
    do_reset(1'b1, 1'b0, 64);
    for (int i = 1; i <= 8; i++) begin
      burst(8, rd);
      vecs++;
      if (bus.sys_wr_addr !== AW'((i * 8) % 64) || level !== AW'(i)) begin
        errs++;
        $display("FAIL wrap_step%0d: wa=%0d lvl=%0d, expected wa=%0d lvl=%0d",
                 i, bus.sys_wr_addr, level, (i * 8) % 64, i);
      end
    end
    repeat (5) @(negedge clk);
    vecs++;
    if (bus.sdram_wr_req !== 1'b0 || level !== AW'(8)) begin
      errs++;
      $display("FAIL full_block: wr_req=%b lvl=%0d, expected wr_req=0 lvl=8", bus.sdram_wr_req, level);
    end
  endtask

  task automatic test_short_ack();
    bit rd;
    do_reset(1'b1, 1'b0, 64);
    burst(5, rd);
    vecs++;
    if (burst_err !== 1'b1 || level !== AW'(1) || bus.sys_wr_addr !== AW'(8)) begin
      errs++;
      $display("FAIL short_ack: err=%b lvl=%0d wa=%0d, expected err=1 lvl=1 wa=8",
               burst_err, level, bus.sys_wr_addr);
    end
    burst(8, rd);
    vecs++;
    if (burst_err !== 1'b1 || level !== AW'(2)) begin
      errs++;
      $display("FAIL err_sticky: err=%b lvl=%0d, expected err=1 lvl=2", burst_err, level);
    end
  endtask

  task automatic test_stray_ack();
    do_reset(1'b0, 1'b0, 0);
    @(negedge clk);
    vecs++;
    if (burst_err !== 1'b0) begin
      errs++; $display("FAIL stray_pre: err=%b, expected 0", burst_err);
    end
    bus.sdram_rd_ack = 1'b1;
    @(negedge clk);
    bus.sdram_rd_ack = 1'b0;
    vecs++;
    if (burst_err !== 1'b1 || level !== '0 || bus.sys_rd_addr !== '0) begin
      errs++;
      $display("FAIL stray_ack: err=%b lvl=%0d ra=%0d, expected err=1 lvl=0 ra=0",
               burst_err, level, bus.sys_rd_addr);
    end
  endtask

  task automatic test_back_to_back_priority();
    bit rd;
    bit exp_rd [4];
    int exp_lvl;
`ifdef SDRAM_SCHED_RR_EN
    exp_rd = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_lvl = 1;
`else
    exp_rd = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_lvl = 5;
`endif
    do_reset(1'b1, 1'b0, 64);
    burst(8, rd);
    burst(8, rd);
    wr_en = 1'b0; rd_en = 1'b1;
    burst(8, rd);
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      burst(8, rd);
      vecs++;
      if (rd !== exp_rd[i]) begin
        errs++; $display("FAIL prio_burst%0d: is_read=%b, expected %b", i, rd, exp_rd[i]);
      end
    end
    vecs++;
    if (level !== AW'(exp_lvl)) begin
      errs++; $display("FAIL prio_level: lvl=%0d, expected %0d", level, exp_lvl);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    init_done = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wrf_usedw = '0; rdf_usedw = '0;
    bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0;
    test_reset();
    test_single_write_then_read();
    test_wrap_full();
    test_short_ack();
    test_stray_ack();
    test_back_to_back_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
